lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: ADDRESS, 10, word-address width driven to the data memory (1024 words).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  core requests a memory access.
REQ-005 req_ready  output  1  controller accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu (loads); 000 sb, 001 sh, 010 sw (stores).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  load result, extended per funct3; 0 for stores and errors.
REQ-012 rsp_err  output  1  valid with rsp_valid; misaligned, illegal funct3 or out-of-range access.
REQ-013 MemRW  output  1  memory direction: 0 read, 1 write (write commits at posedge).
REQ-014 Addr  output  ADDRESS  memory word address.
REQ-015 DataW  output  32  memory write data.
REQ-016 DataR  input  32  memory read data, combinational from Addr while MemRW = 0.

Function
REQ-017 States SHALL be IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-018 IDLE: on req_valid, latch we, funct3, addr, wdata. Error -> RESP. Load -> RD. sw -> WR. sb/sh -> RD.
REQ-019 Errors: halfword with addr[0]=1; word with addr[1:0]!=0; funct3 in {011,110,111}, or store funct3 in {100,101}; addr[31:ADDRESS+2] != 0.
REQ-020 An erroring request SHALL never assert MemRW.
REQ-021 RD: MemRW=0, Addr=latched addr[ADDRESS+1:2]; DataR captured into a data register at the exiting edge. Next state is RESP for loads and WR for sb/sh.
REQ-022 WR: MemRW=1, Addr as in RD, DataW = merged word; next state is RESP.
REQ-023 Merge: sb replaces byte lane addr[1:0] with wdata[7:0]; sh replaces lane pair addr[1] with wdata[15:0]; sw uses wdata unchanged. Other lanes come from the captured read word.
REQ-024 Load extract: select lane by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
REQ-025 RESP: rsp_valid=1 for exactly one cycle, with rsp_rdata and rsp_err valid; next state is IDLE. There is no response backpressure.
REQ-026 Latency from accept edge to rsp_valid cycle: error 1 cycle; sw 2 cycles; load 2 cycles; sb/sh 3 cycles.
REQ-027 Outside RD/WR, MemRW=0, Addr=0, DataW=0. Outside RESP, rsp_valid=0, rsp_rdata=0, rsp_err=0.
REQ-028 Back-to-back: a request held on req_valid during RESP SHALL be accepted in the following IDLE cycle. There is one request in flight maximum.
REQ-029 Request inputs are ignored when req_ready=0.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, clear the latched request and data registers, and drive MemRW=0, Addr=0, DataW=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1.
REQ-031 Reset asserted in WR SHALL suppress the pending write: MemRW falls before the next posedge. No response is produced for the aborted request.

Verification
REQ-032 Word 3 = 0x11223344; sb addr 0x0D, wdata 0xAB -> RD, WR, RESP; word 3 = 0x1122AB44; rsp_err=0.
REQ-033 Word 3 = 0x8899AABB; lh at 0x0E -> rsp_rdata=0xFFFF8899; lhu at 0x0E -> rsp_rdata=0x00008899; lb at 0x0C -> rsp_rdata=0xFFFFFFBB.
REQ-034 sw addr 0x02 -> rsp_valid on the first cycle after accept with rsp_err=1; MemRW stays 0 and memory is unchanged.
REQ-035 sw addr 0x1000 (ADDRESS=10) -> rsp_err=1, no write; funct3=011 load -> rsp_err=1.
REQ-036 req_valid held high with sw 0x10 then lw 0x10 -> second request accepted the cycle after the first rsp_valid; it returns the stored value.
REQ-037 Assert reset_n=0 during WR of sh -> MemRW=0 immediately; target word unchanged; after release, req_ready=1 and rsp_valid=0.

Source files
------------

// File: rtl/lsu_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : lsu_ctrl
// Description : Load/store unit controller for a word-addressed data memory;
//               byte/halfword stores use a read-modify-write sequence.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int ADDRESS = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic               MemRW,
    output logic [ADDRESS-1:0] Addr,
    output logic [31:0]        DataW,
    input  logic [31:0]        DataR
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_we;
    logic [2:0]         r_funct3;
    logic [ADDRESS+1:0] r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_data;
    logic               r_err;

    logic               w_req_err;
    logic [31:0]        w_merged;
    logic [31:0]        w_load;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;

    // Request legality is judged on the live inputs so the IDLE branch can route errors straight to RESP.
    always_comb begin
        w_req_err = 1'b0;
        case (req_funct3)
            3'b000:  w_req_err = 1'b0;
            3'b001:  w_req_err = req_addr[0];
            3'b010:  w_req_err = |req_addr[1:0];
            3'b100:  w_req_err = req_we;
            3'b101:  w_req_err = req_we | req_addr[0];
            default: w_req_err = 1'b1;
        endcase
        if (|req_addr[31:ADDRESS+2]) begin
            w_req_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_data   <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req_valid) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr[ADDRESS+1:0];
                r_wdata  <= req_wdata;
                r_err    <= w_req_err;
            end
            if (r_state == S_RD) begin
                r_data <= DataR;
            end
        end
    end

    always_comb begin
        w_merged = r_data;
        case (r_funct3[1:0])
            2'b00: begin
                case (r_addr[1:0])
                    2'd0:    w_merged[7:0]   = r_wdata[7:0];
                    2'd1:    w_merged[15:8]  = r_wdata[7:0];
                    2'd2:    w_merged[23:16] = r_wdata[7:0];
                    default: w_merged[31:24] = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_addr[1]) w_merged[31:16] = r_wdata[15:0];
                else           w_merged[15:0]  = r_wdata[15:0];
            end
            default: w_merged = r_wdata;
        endcase
    end

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = r_data[7:0];
            2'd1:    w_byte = r_data[15:8];
            2'd2:    w_byte = r_data[23:16];
            default: w_byte = r_data[31:24];
        endcase
        w_half = r_addr[1] ? r_data[31:16] : r_data[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = r_data;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        MemRW     = 1'b0;
        Addr      = '0;
        DataW     = 32'd0;
        rsp_valid = 1'b0;
        rsp_rdata = 32'd0;
        rsp_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_req_err)                w_next = S_RESP;
                    else if (!req_we)             w_next = S_RD;
                    else if (req_funct3 == 3'b010) w_next = S_WR;
                    else                          w_next = S_RD;
                end
            end
            S_RD: begin
                Addr   = r_addr[ADDRESS+1:2];
                w_next = r_we ? S_WR : S_RESP;
            end
            S_WR: begin
                MemRW  = 1'b1;
                Addr   = r_addr[ADDRESS+1:2];
                DataW  = w_merged;
                w_next = S_RESP;
            end
            default: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err;
                rsp_rdata = (r_err || r_we) ? 32'd0 : w_load;
                w_next    = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_lsu_ctrl
// Description : Self-checking bench for lsu_ctrl with a word memory and a
//               byte-level reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_lsu_ctrl;

    localparam int ADDRESS = 10;

    logic               clk;
    logic               reset_n;
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [2:0]         req_funct3;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;
    logic               rsp_valid;
    logic [31:0]        rsp_rdata;
    logic               rsp_err;
    logic               MemRW;
    logic [ADDRESS-1:0] Addr;
    logic [31:0]        DataW;
    logic [31:0]        DataR;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        pre_en;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    lsu_ctrl #(.ADDRESS(ADDRESS)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .MemRW(MemRW), .Addr(Addr), .DataW(DataW), .DataR(DataR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign DataR = mem[Addr];
    always @(posedge clk) begin
        if (MemRW)       mem[Addr]     <= DataW;
        else if (pre_en) mem[pre_addr] <= pre_data;
    end

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    // Reference model: access size in bytes, legality and byte-lane arithmetic.
    function automatic int ref_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        if ((a % ref_size(f3)) != 0) return 1'b1;
        return a >= 32'd4096;
    endfunction

    function automatic logic [31:0] ref_mask(input int size);
        logic [63:0] m;
        m = (64'd1 << (8 * size)) - 64'd1;
        return m[31:0];
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] word, val, m;
        int size, off;
        word = ref_mem[a[11:2]];
        size = ref_size(f3);
        off  = int'(a % 4);
        m    = ref_mask(size);
        val  = (word >> (8 * off)) & m;
        if (!f3[2] && size < 4 && (((val >> (8 * size - 1)) & 32'd1) != 0))
            val = val | ~m;
        return val;
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] wd);
        logic [31:0] m;
        int off;
        m   = ref_mask(ref_size(f3));
        off = int'(a % 4);
        return (ref_mem[a[11:2]] & ~(m << (8 * off))) | ((wd & m) << (8 * off));
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output logic wrote);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 0; rd = 32'd0; er = 1'b0; wrote = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (MemRW) wrote = 1'b1;
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; er = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; pre_en = 1'b0; pre_addr = 10'd0; pre_data = 32'd0;
        #2;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, MemRW} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 1000", {req_ready, rsp_valid, rsp_err, MemRW});
        end
        n_cmp++;
        if ({Addr, DataW, rsp_rdata} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got Addr=%h DataW=%h rdata=%h want 0", Addr, DataW, rsp_rdata);
        end
        for (int i = 0; i < 16; i++) poke(10'(i), $urandom);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_store_byte;
        int lat; logic [31:0] rd; logic er, wr;
        poke(10'd3, 32'h11223344);
        issue(1'b1, 3'b000, 32'h0D, 32'h000000AB, lat, rd, er, wr);
        n_cmp++;
        if (lat !== 3 || er !== 1'b0) begin
            n_bad++; $display("FAIL sb_resp: got lat=%0d err=%b want lat=3 err=0", lat, er);
        end
        n_cmp++;
        if (mem[3] !== 32'h1122AB44) begin
            n_bad++; $display("FAIL sb_merge: got %h want 1122ab44", mem[3]);
        end
    endtask

    task automatic test_load_ext;
        int lat; logic [31:0] rd; logic er, wr;
        poke(10'd3, 32'h8899AABB);
        issue(1'b0, 3'b001, 32'h0E, 32'd0, lat, rd, er, wr);
        n_cmp++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hFFFF8899) begin
            n_bad++; $display("FAIL lh: got lat=%0d err=%b data=%h want 2/0/ffff8899", lat, er, rd);
        end
        issue(1'b0, 3'b101, 32'h0E, 32'd0, lat, rd, er, wr);
        n_cmp++;
        if (rd !== 32'h00008899) begin
            n_bad++; $display("FAIL lhu: got %h want 00008899", rd);
        end
        issue(1'b0, 3'b000, 32'h0C, 32'd0, lat, rd, er, wr);
        n_cmp++;
        if (rd !== 32'hFFFFFFBB) begin
            n_bad++; $display("FAIL lb: got %h want ffffffbb", rd);
        end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] rd; logic er, wr;
        poke(10'd0, 32'h5A5A1234);
        issue(1'b1, 3'b010, 32'h02, 32'hDEADBEEF, lat, rd, er, wr);
        n_cmp++;
        if (lat !== 1 || er !== 1'b1 || wr !== 1'b0 || rd !== 32'd0) begin
            n_bad++; $display("FAIL sw_misalign: got lat=%0d err=%b wrote=%b data=%h want 1/1/0/0", lat, er, wr, rd);
        end
        issue(1'b1, 3'b010, 32'h1000, 32'hDEADBEEF, lat, rd, er, wr);
        n_cmp++;
        if (lat !== 1 || er !== 1'b1 || wr !== 1'b0) begin
            n_bad++; $display("FAIL sw_range: got lat=%0d err=%b wrote=%b want 1/1/0", lat, er, wr);
        end
        n_cmp++;
        if (mem[0] !== 32'h5A5A1234) begin
            n_bad++; $display("FAIL err_nowrite: got %h want 5a5a1234", mem[0]);
        end
        issue(1'b0, 3'b011, 32'h04, 32'd0, lat, rd, er, wr);
        n_cmp++;
        if (lat !== 1 || er !== 1'b1) begin
            n_bad++; $display("FAIL f3_011: got lat=%0d err=%b want 1/1", lat, er);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] wd;
        int gap, t;
        logic seen;
        wd = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = wd;
        @(posedge clk);
        #1 req_we = 1'b0; req_wdata = 32'd0;
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        n_cmp++;
        if (!seen || req_ready !== 1'b0) begin
            n_bad++; $display("FAIL b2b_first: got seen=%b ready=%b want 1/0", seen, req_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL b2b_ready: got %b want 1", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        gap = 0; t = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            t++;
            if (rsp_valid) begin gap = t; break; end
        end
        n_cmp++;
        if (gap !== 3 || rsp_rdata !== wd || rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL b2b_second: got gap=%0d data=%h want gap=3 data=%h", gap, rsp_rdata, wd);
        end
        ref_mem[4] = wd;
    endtask

    task automatic test_reset_in_write;
        poke(10'd5, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h16; req_wdata = 32'h00001357;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (MemRW !== 1'b1) begin
            n_bad++; $display("FAIL rst_wr_pre: got MemRW=%b want 1", MemRW);
        end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (MemRW !== 1'b0 || Addr !== '0 || DataW !== 32'd0) begin
            n_bad++; $display("FAIL rst_wr_abort: got MemRW=%b Addr=%h DataW=%h want 0", MemRW, Addr, DataW);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (mem[5] !== 32'hCAFEF00D) begin
            n_bad++; $display("FAIL rst_wr_mem: got %h want cafef00d", mem[5]);
        end
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
                n_bad++; $display("FAIL rst_wr_after: got ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
            end
        end
    endtask

    task automatic test_random;
        int lat, exp_lat;
        logic [31:0] rd, a, wd, exp_rd;
        logic er, wr, we, exp_er;
        logic [2:0] f3;
        for (int i = 0; i < 16; i++) poke(10'(i), $urandom);
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(12, 31));
            wd = $urandom;
            exp_er  = ref_err(we, f3, a);
            exp_rd  = (exp_er || we) ? 32'd0 : ref_load(f3, a);
            exp_lat = exp_er ? 1 : (!we ? 2 : (ref_size(f3) == 4 ? 2 : 3));
            issue(we, f3, a, wd, lat, rd, er, wr);
            n_cmp++;
            if (lat !== exp_lat || er !== exp_er || rd !== exp_rd) begin
                n_bad++;
                $display("FAIL rand_rsp[%0d]: we=%b f3=%0d a=%h got lat=%0d err=%b data=%h want lat=%0d err=%b data=%h",
                         n, we, f3, a, lat, er, rd, exp_lat, exp_er, exp_rd);
            end
            if (exp_er) begin
                n_cmp++;
                if (wr !== 1'b0) begin
                    n_bad++; $display("FAIL rand_err_write[%0d]: got MemRW=1 want 0", n);
                end
            end else begin
                if (we) ref_mem[a[11:2]] = ref_store(f3, a, wd);
                n_cmp++;
                if (mem[a[11:2]] !== ref_mem[a[11:2]]) begin
                    n_bad++; $display("FAIL rand_mem[%0d]: got %h want %h", n, mem[a[11:2]], ref_mem[a[11:2]]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_store_byte;
        test_load_ext;
        test_errors;
        test_back_to_back;
        test_reset_in_write;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
